// File: rtl/imem_boot_loader.sv
// Byte-serial program loader for the instruction memory. It receives a framed image
// (a 4-byte word count, then 4*N payload bytes, then one XOR checksum byte), writes the
// big-endian words to consecutive word addresses, and holds the core in reset until the
// image has been verified.
module imem_boot_loader #(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int unsigned MAX_WORDS = 262144,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             core_rst,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] words_loaded
);

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StData,
    StWrite,
    StCsum,
    StDone,
    StError
  } state_t;

  state_t           r_state;
  logic [1:0]       r_byte_cnt;
  logic [31:0]      r_n;
  logic [31:0]      r_word;
  logic [7:0]       r_xor;
  logic             r_rx_ready;
  logic             r_mem_we;
  logic [31:0]      r_mem_addr;
  logic [31:0]      r_mem_wdata;
  logic             r_core_rst;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [CNT_W-1:0] r_words_loaded;

  logic             w_xfer;
  logic [7:0]       w_xor_next;
  logic [31:0]      w_hdr_next;
  logic [31:0]      w_word_next;
  logic [CNT_W-1:0] w_wl_inc;
  logic [31:0]      w_addr;
  logic             w_last_byte;

  assign w_xfer      = rx_valid & r_rx_ready;
  assign w_xor_next  = r_xor ^ rx_data;
  assign w_hdr_next  = {r_n[23:0], rx_data};
  assign w_word_next = {r_word[23:0], rx_data};
  assign w_wl_inc    = r_words_loaded + CNT_W'(1);
  // Byte address of the word about to be written; wraps modulo 2^32.
  assign w_addr      = BASE_ADDR + (32'(r_words_loaded) << 2);
  assign w_last_byte = (r_byte_cnt == 2'd3);

  // Loader FSM; every status output is a flop updated alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= StIdle;
      r_byte_cnt     <= 2'd0;
      r_n            <= 32'd0;
      r_word         <= 32'd0;
      r_xor          <= 8'd0;
      r_rx_ready     <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= BASE_ADDR;
      r_mem_wdata    <= 32'd0;
      r_core_rst     <= 1'b1;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
      r_words_loaded <= '0;
    end else begin
      case (r_state)
        StIdle, StError: begin
          if (start) begin
            r_state        <= StHdr;
            r_byte_cnt     <= 2'd0;
            r_xor          <= 8'd0;
            r_words_loaded <= '0;
            r_err          <= 1'b0;
            r_rx_ready     <= 1'b1;
            r_busy         <= 1'b1;
          end
        end
        StHdr: begin
          if (w_xfer) begin
            r_n        <= w_hdr_next;
            r_xor      <= w_xor_next;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (w_last_byte) begin
              if (w_hdr_next == 32'd0) begin
                r_state <= StCsum;
              end else if (w_hdr_next > 32'(MAX_WORDS)) begin
                r_state    <= StError;
                r_rx_ready <= 1'b0;
                r_busy     <= 1'b0;
                r_err      <= 1'b1;
              end else begin
                r_state <= StData;
              end
            end
          end
        end
        StData: begin
          if (w_xfer) begin
            r_word     <= w_word_next;
            r_xor      <= w_xor_next;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (w_last_byte) begin
              r_state     <= StWrite;
              r_rx_ready  <= 1'b0;
              r_mem_we    <= 1'b1;
              r_mem_addr  <= w_addr;
              r_mem_wdata <= w_word_next;
            end
          end
        end
        StWrite: begin
          r_mem_we       <= 1'b0;
          r_rx_ready     <= 1'b1;
          r_words_loaded <= w_wl_inc;
          r_state        <= (32'(w_wl_inc) == r_n) ? StCsum : StData;
        end
        StCsum: begin
          if (w_xfer) begin
            r_rx_ready <= 1'b0;
            r_busy     <= 1'b0;
            if (rx_data == r_xor) begin
              r_state    <= StDone;
              r_done     <= 1'b1;
              r_core_rst <= 1'b0;
            end else begin
              r_state <= StError;
              r_err   <= 1'b1;
            end
          end
        end
        StDone: begin
          // Terminal until reset.
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign rx_ready     = r_rx_ready;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign core_rst     = r_core_rst;
  assign busy         = r_busy;
  assign done         = r_done;
  assign err          = r_err;
  assign words_loaded = r_words_loaded;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: frames are built by a byte-level model,
// driven with optional valid gaps, and the observed writes and status are compared
// against the model's expectations.
module tb_imem_boot_loader;

  localparam logic [31:0] BASE = 32'd0;

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [31:0] word_q_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_rst;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] words_loaded;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] cap_addr[$];
  logic [31:0] cap_data[$];
  bit          ready_in_write = 1'b0;

  imem_boot_loader #(
    .BASE_ADDR(BASE),
    .MAX_WORDS(262144),
    .CNT_W    (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .core_rst    (core_rst),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Record every write pulse; WRITE is the only state with mem_we high.
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      cap_addr.push_back(mem_addr);
      cap_data.push_back(mem_wdata);
      if (rx_ready) ready_in_write = 1'b1;
    end
  end

  // Frame model: count MSB first, words big-endian, then XOR of all bytes (optionally spoiled).
  task automatic build_frame(input word_q_t words, input logic [7:0] csum_flip,
                             output byte_q_t frame);
    logic [31:0] n;
    logic [7:0]  x;
    frame = {};
    n = 32'(words.size());
    for (int i = 3; i >= 0; i--) frame.push_back(n[8*i +: 8]);
    foreach (words[w]) begin
      for (int i = 3; i >= 0; i--) frame.push_back(words[w][8*i +: 8]);
    end
    x = 8'd0;
    foreach (frame[i]) x = x ^ frame[i];
    frame.push_back(x ^ csum_flip);
  endtask

  function automatic logic [31:0] exp_addr(input int idx);
    return BASE + 32'(idx) * 32'd4;
  endfunction

  task automatic do_reset();
    rx_valid = 1'b0;
    start    = 1'b0;
    rst      = 1'b1;
    cap_addr = {};
    cap_data = {};
    ready_in_write = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drives up to 'limit' bytes starting at the current negedge. gap_mode: 0 none,
  // 1 every other cycle idle, 2 random idles. start is pulsed once when byte start_at is due.
  task automatic send_frame(input byte_q_t frame, input int limit, input int gap_mode,
                            input int start_at, output int sent, output int cycles);
    int  idx;
    bit  xfer;
    bit  fired;
    idx    = 0;
    cycles = 0;
    fired  = 1'b0;
    while (idx < limit && cycles < 40 * limit + 100) begin
      if ((gap_mode == 1 && cycles[0]) || (gap_mode == 2 && $urandom_range(0, 2) == 0)) begin
        rx_valid = 1'b0;
      end else begin
        rx_valid = 1'b1;
        rx_data  = frame[idx];
      end
      if (!fired && idx == start_at) begin
        start = 1'b1;
        fired = 1'b1;
      end else begin
        start = 1'b0;
      end
      xfer = rx_valid && rx_ready;
      @(negedge clk);
      if (xfer) idx++;
      cycles++;
    end
    rx_valid = 1'b0;
    start    = 1'b0;
    sent     = idx;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rx_ready: got %b want 0", rx_ready); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    n_checks++; if (mem_addr !== BASE) begin n_fail++; $display("FAIL reset_mem_addr: got %h want %h", mem_addr, BASE); end
    n_checks++; if (mem_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    n_checks++; if ({core_rst, busy, done, err} !== 4'b1000) begin n_fail++; $display("FAIL reset_status: got %b want 1000", {core_rst, busy, done, err}); end
    n_checks++; if (words_loaded !== 32'd0) begin n_fail++; $display("FAIL reset_words: got %0d want 0", words_loaded); end
    // start must be ignored until it is pulsed; idle stays idle without it.
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0 || rx_ready !== 1'b0) begin n_fail++; $display("FAIL idle_hold: busy %b rx_ready %b want 0 0", busy, rx_ready); end
  endtask

  task automatic test_normal();
    word_q_t w;
    byte_q_t f;
    int sent, cyc;
    w = {32'h2008_0005, 32'h0109_5020};
    build_frame(w, 8'h00, f);
    do_reset();
    pulse_start();
    n_checks++; if (busy !== 1'b1 || rx_ready !== 1'b1) begin n_fail++; $display("FAIL normal_hdr: busy %b rx_ready %b want 1 1", busy, rx_ready); end
    send_frame(f, f.size(), 0, -1, sent, cyc);
    n_checks++; if (sent !== f.size()) begin n_fail++; $display("FAIL normal_sent: got %0d want %0d", sent, f.size()); end
    n_checks++; if (cyc !== 4 + 5 * 2 + 1) begin n_fail++; $display("FAIL normal_cycles: got %0d want %0d", cyc, 15); end
    n_checks++; if ({done, err, core_rst, busy, rx_ready} !== 5'b10000) begin n_fail++; $display("FAIL normal_status: got %b want 10000", {done, err, core_rst, busy, rx_ready}); end
    n_checks++; if (words_loaded !== 32'd2) begin n_fail++; $display("FAIL normal_words: got %0d want 2", words_loaded); end
    n_checks++; if (cap_addr.size() !== 2) begin n_fail++; $display("FAIL normal_nwrites: got %0d want 2", cap_addr.size()); end
    for (int i = 0; i < cap_addr.size() && i < w.size(); i++) begin
      n_checks++; if (cap_addr[i] !== exp_addr(i) || cap_data[i] !== w[i]) begin n_fail++; $display("FAIL normal_write%0d: got %h/%h want %h/%h", i, cap_addr[i], cap_data[i], exp_addr(i), w[i]); end
    end
    n_checks++; if (mem_addr !== exp_addr(1) || mem_wdata !== w[1]) begin n_fail++; $display("FAIL normal_hold: got %h/%h want %h/%h", mem_addr, mem_wdata, exp_addr(1), w[1]); end
    // DONE ignores start.
    pulse_start();
    repeat (2) @(negedge clk);
    n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL done_sticky: done %b busy %b want 1 0", done, busy); end
  endtask

  task automatic test_empty();
    word_q_t w;
    byte_q_t f;
    int sent, cyc;
    w = {};
    build_frame(w, 8'h00, f);
    do_reset();
    pulse_start();
    send_frame(f, f.size(), 0, -1, sent, cyc);
    n_checks++; if (cyc !== 5) begin n_fail++; $display("FAIL empty_cycles: got %0d want 5", cyc); end
    n_checks++; if ({done, err, core_rst} !== 3'b100) begin n_fail++; $display("FAIL empty_status: got %b want 100", {done, err, core_rst}); end
    n_checks++; if (cap_addr.size() !== 0 || words_loaded !== 32'd0) begin n_fail++; $display("FAIL empty_writes: got %0d writes, words %0d want 0 0", cap_addr.size(), words_loaded); end
  endtask

  task automatic test_bad_csum();
    word_q_t w;
    byte_q_t f;
    int sent, cyc;
    w = {32'h2008_0005, 32'h0109_5020};
    build_frame(w, 8'h01, f);
    do_reset();
    pulse_start();
    send_frame(f, f.size(), 0, -1, sent, cyc);
    n_checks++; if (f[f.size()-1] !== 8'h56) begin n_fail++; $display("FAIL bad_frame_csum: got %h want 56", f[f.size()-1]); end
    n_checks++; if ({err, core_rst, done, busy} !== 4'b1100) begin n_fail++; $display("FAIL bad_status: got %b want 1100", {err, core_rst, done, busy}); end
    n_checks++; if (cap_addr.size() !== 2 || words_loaded !== 32'd2) begin n_fail++; $display("FAIL bad_writes: got %0d writes, words %0d want 2 2", cap_addr.size(), words_loaded); end
    build_frame(w, 8'h00, f);
    pulse_start();
    n_checks++; if (err !== 1'b0 || words_loaded !== 32'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL restart_clear: err %b words %0d busy %b want 0 0 1", err, words_loaded, busy); end
    cap_addr = {};
    cap_data = {};
    send_frame(f, f.size(), 0, -1, sent, cyc);
    n_checks++; if ({done, err, core_rst} !== 3'b100) begin n_fail++; $display("FAIL restart_status: got %b want 100", {done, err, core_rst}); end
    n_checks++; if (cap_addr.size() !== 2) begin n_fail++; $display("FAIL restart_nwrites: got %0d want 2", cap_addr.size()); end
    for (int i = 0; i < cap_addr.size() && i < w.size(); i++) begin
      n_checks++; if (cap_addr[i] !== exp_addr(i) || cap_data[i] !== w[i]) begin n_fail++; $display("FAIL restart_write%0d: got %h/%h want %h/%h", i, cap_addr[i], cap_data[i], exp_addr(i), w[i]); end
    end
  endtask

  task automatic test_oversize();
    byte_q_t f;
    int sent, cyc;
    f = {8'h00, 8'h04, 8'h00, 8'h01};
    do_reset();
    pulse_start();
    send_frame(f, 4, 0, -1, sent, cyc);
    n_checks++; if (cyc !== 4) begin n_fail++; $display("FAIL over_cycles: got %0d want 4", cyc); end
    n_checks++; if ({err, core_rst, busy, rx_ready} !== 4'b1100) begin n_fail++; $display("FAIL over_status: got %b want 1100", {err, core_rst, busy, rx_ready}); end
    rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    n_checks++; if (rx_ready !== 1'b0 || cap_addr.size() !== 0) begin n_fail++; $display("FAIL over_after: rx_ready %b writes %0d want 0 0", rx_ready, cap_addr.size()); end
    // Exactly MAX_WORDS is accepted.
    f = {8'h00, 8'h04, 8'h00, 8'h00};
    do_reset();
    pulse_start();
    send_frame(f, 4, 0, -1, sent, cyc);
    n_checks++; if ({err, busy, rx_ready} !== 3'b011) begin n_fail++; $display("FAIL max_accept: got %b want 011", {err, busy, rx_ready}); end
  endtask

  task automatic test_backpressure();
    word_q_t w;
    byte_q_t f;
    int sent, cyc;
    w = {32'h2008_0005, 32'h0109_5020};
    build_frame(w, 8'h00, f);
    do_reset();
    pulse_start();
    send_frame(f, f.size(), 1, 6, sent, cyc);
    n_checks++; if (sent !== f.size()) begin n_fail++; $display("FAIL bp_sent: got %0d want %0d", sent, f.size()); end
    n_checks++; if ({done, err, core_rst} !== 3'b100 || words_loaded !== 32'd2) begin n_fail++; $display("FAIL bp_status: got %b words %0d want 100 2", {done, err, core_rst}, words_loaded); end
    n_checks++; if (cap_addr.size() !== 2) begin n_fail++; $display("FAIL bp_nwrites: got %0d want 2", cap_addr.size()); end
    for (int i = 0; i < cap_addr.size() && i < w.size(); i++) begin
      n_checks++; if (cap_addr[i] !== exp_addr(i) || cap_data[i] !== w[i]) begin n_fail++; $display("FAIL bp_write%0d: got %h/%h want %h/%h", i, cap_addr[i], cap_data[i], exp_addr(i), w[i]); end
    end
    n_checks++; if (ready_in_write !== 1'b0) begin n_fail++; $display("FAIL bp_ready_in_write: got %b want 0", ready_in_write); end
  endtask

  task automatic test_reset_mid();
    word_q_t w;
    byte_q_t f;
    int sent, cyc;
    w = {32'h2008_0005, 32'h0109_5020};
    build_frame(w, 8'h00, f);
    do_reset();
    pulse_start();
    send_frame(f, 6, 0, -1, sent, cyc);
    rst = 1'b1;
    #1;
    n_checks++; if ({core_rst, rx_ready, busy, done, err} !== 5'b10000 || words_loaded !== 32'd0) begin n_fail++; $display("FAIL rstmid_status: got %b words %0d want 10000 0", {core_rst, rx_ready, busy, done, err}, words_loaded); end
    cap_addr = {};
    cap_data = {};
    @(negedge clk);
    rst = 1'b0;
    pulse_start();
    send_frame(f, f.size(), 0, -1, sent, cyc);
    n_checks++; if ({done, err, core_rst} !== 3'b100 || cap_addr.size() !== 2) begin n_fail++; $display("FAIL rstmid_reload: got %b writes %0d want 100 2", {done, err, core_rst}, cap_addr.size()); end
  endtask

  task automatic test_random();
    word_q_t w;
    byte_q_t f;
    int sent, cyc, n;
    logic [7:0] flip;
    for (int it = 0; it < 20; it++) begin
      n = $urandom_range(0, 6);
      w = {};
      for (int i = 0; i < n; i++) w.push_back($urandom);
      flip = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      build_frame(w, flip, f);
      do_reset();
      pulse_start();
      send_frame(f, f.size(), 2, -1, sent, cyc);
      n_checks++; if (sent !== f.size()) begin n_fail++; $display("FAIL rnd%0d_sent: got %0d want %0d", it, sent, f.size()); end
      n_checks++; if (done !== (flip == 8'h00) || err !== (flip != 8'h00) || core_rst !== (flip != 8'h00)) begin n_fail++; $display("FAIL rnd%0d_status: done %b err %b core_rst %b flip %h", it, done, err, core_rst, flip); end
      n_checks++; if (words_loaded !== 32'(n) || cap_addr.size() !== n) begin n_fail++; $display("FAIL rnd%0d_count: words %0d writes %0d want %0d", it, words_loaded, cap_addr.size(), n); end
      for (int i = 0; i < cap_addr.size() && i < n; i++) begin
        n_checks++; if (cap_addr[i] !== exp_addr(i) || cap_data[i] !== w[i]) begin n_fail++; $display("FAIL rnd%0d_write%0d: got %h/%h want %h/%h", it, i, cap_addr[i], cap_data[i], exp_addr(i), w[i]); end
      end
      n_checks++; if (ready_in_write !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_ready_in_write", it); end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_empty();
    test_bad_csum();
    test_oversize();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
